// File: rtl/request_grant_sequencer_18_if.sv
// Request/grant bus bundle for the 18-source round-robin sequencer.
// The master side drives requests and acknowledge; the slave (sequencer) drives grant/pending status.
interface request_grant_sequencer_18_if;
  logic [17:0] Request;
  logic        Ack;
  logic [17:0] Grant;
  logic [4:0]  GrantIndex;
  logic        GrantValid;
  logic        Timeout;
  logic [17:0] PendingVec;
  logic        AnyPending;

  modport master (
    output Request, Ack,
    input  Grant, GrantIndex, GrantValid, Timeout, PendingVec, AnyPending
  );

  modport slave (
    input  Request, Ack,
    output Grant, GrantIndex, GrantValid, Timeout, PendingVec, AnyPending
  );
endinterface

// File: rtl/request_grant_sequencer_18.sv
// Edge-triggered request latching with a round-robin grant sequencer over 18 sources.
// A grant is held until Ack or until TimeoutCycles elapse, then one IDLE cycle follows.
module request_grant_sequencer_18 #(
  parameter logic [17:0] BubblesMask   = 18'd0,
  parameter logic [7:0]  TimeoutCycles = 8'd16
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  request_grant_sequencer_18_if.slave       bus
);

  localparam int N = 18;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t      r_state;
  logic [17:0] r_prev;
  logic [17:0] r_pend;
  logic [17:0] r_grant;
  logic [4:0]  r_gidx;
  logic [4:0]  r_ptr;
  logic [7:0]  r_cnt;
  logic        r_gvld;
  logic        r_tout;

  logic [17:0] w_req;
  logic [17:0] w_edge;
  logic [17:0] w_clr;
  logic [17:0] w_pick_onehot;
  logic [4:0]  w_pick;
  logic        w_any;
  logic        w_ack_grant;
  logic        w_tmo_hit;

  function automatic logic [4:0] next_idx(input logic [4:0] idx);
    return (idx == 5'd17) ? 5'd0 : idx + 5'd1;
  endfunction

  // First pending source strictly after ptr, wrapping 17 -> 0.
  function automatic logic [4:0] rr_pick(input logic [17:0] pend, input logic [4:0] ptr);
    logic [4:0] idx;
    logic [4:0] pick;
    logic       found;
    idx   = ptr;
    pick  = 5'd0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = next_idx(idx);
      if (!found && pend[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign w_req         = bus.Request ^ BubblesMask;
  assign w_edge        = w_req & ~r_prev;
  assign w_any         = |r_pend;
  assign w_pick        = rr_pick(r_pend, r_ptr);
  assign w_pick_onehot = 18'd1 << w_pick;
  assign w_ack_grant   = (r_state == GRANT) && bus.Ack;
  assign w_tmo_hit     = (TimeoutCycles != 8'd0) && (r_cnt == TimeoutCycles - 8'd1);
  // r_grant is already one-hot on the granted index, so it doubles as the clear mask.
  assign w_clr         = w_ack_grant ? r_grant : 18'd0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev <= '0;
      r_pend <= '0;
    end else begin
      r_prev <= w_req;
      // A new edge on the bit being cleared wins so the event is not lost.
      r_pend <= (r_pend & ~w_clr) | w_edge;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_ptr   <= 5'd17;
      r_cnt   <= '0;
      r_grant <= '0;
      r_gidx  <= '0;
      r_gvld  <= 1'b0;
      r_tout  <= 1'b0;
    end else begin
      r_tout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant <= w_pick_onehot;
            r_gidx  <= w_pick;
            r_gvld  <= 1'b1;
            r_cnt   <= '0;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (bus.Ack) begin
            r_ptr   <= r_gidx;
            r_grant <= '0;
            r_gidx  <= '0;
            r_gvld  <= 1'b0;
            r_state <= IDLE;
          end else if (w_tmo_hit) begin
            r_tout  <= 1'b1;
            r_ptr   <= r_gidx;
            r_grant <= '0;
            r_gidx  <= '0;
            r_gvld  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
      endcase
    end
  end

  assign bus.Grant      = r_grant;
  assign bus.GrantIndex = r_gidx;
  assign bus.GrantValid = r_gvld;
  assign bus.Timeout    = r_tout;
  assign bus.PendingVec = r_pend;
  assign bus.AnyPending = w_any;

endmodule

// File: tb/tb_request_grant_sequencer_18.sv
// Randomized scoreboard bench for request_grant_sequencer_18 with a behavioural reference model.
module tb_request_grant_sequencer_18;

  localparam logic [17:0] MASK = 18'h00080;
  localparam int          TO   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  request_grant_sequencer_18_if bus();

  request_grant_sequencer_18 #(
    .BubblesMask  (MASK),
    .TimeoutCycles(8'(TO))
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  typedef struct packed {
    logic [17:0] grant;
    logic [4:0]  idx;
    logic        vld;
    logic        tout;
    logic [17:0] pend;
  } snap_t;

  snap_t sb_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    mon_en  = 1'b0;
  int    cyc     = 0;

  // Reference model: pending set, last-served pointer, current grantee (-1 = none), cycles held.
  bit          m_pend[18];
  bit          m_rprev[18];
  int          m_ptr;
  int          m_gidx;
  int          m_held;
  bit          m_tout;
  logic [17:0] mask_v;

  task automatic model_reset();
    for (int i = 0; i < 18; i++) begin
      m_pend[i]  = 1'b0;
      m_rprev[i] = 1'b0;
    end
    m_ptr  = 17;
    m_gidx = -1;
    m_held = 0;
    m_tout = 1'b0;
  endtask

  task automatic model_step(input logic [17:0] req, input logic ack);
    bit r[18];
    int clr;
    int sel;
    mask_v = MASK;
    for (int i = 0; i < 18; i++) r[i] = req[i] ^ mask_v[i];
    clr    = -1;
    m_tout = 1'b0;
    if (m_gidx < 0) begin
      for (int off = 1; off <= 18; off++) begin
        sel = (m_ptr + off) % 18;
        if (m_pend[sel]) begin
          m_gidx = sel;
          m_held = 0;
          break;
        end
      end
    end else if (ack) begin
      clr    = m_gidx;
      m_ptr  = m_gidx;
      m_gidx = -1;
    end else begin
      m_held++;
      if (TO != 0 && m_held == TO) begin
        m_tout = 1'b1;
        m_ptr  = m_gidx;
        m_gidx = -1;
      end
    end
    for (int i = 0; i < 18; i++) begin
      if (i == clr) m_pend[i] = 1'b0;
      if (r[i] && !m_rprev[i]) m_pend[i] = 1'b1;
      m_rprev[i] = r[i];
    end
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s.grant = (m_gidx >= 0) ? (18'd1 << m_gidx) : 18'd0;
    s.idx   = (m_gidx >= 0) ? 5'(m_gidx) : 5'd0;
    s.vld   = (m_gidx >= 0);
    s.tout  = m_tout;
    for (int i = 0; i < 18; i++) s.pend[i] = m_pend[i];
    return s;
  endfunction

  function automatic int model_pend_count();
    int c = 0;
    for (int i = 0; i < 18; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  // Monitor: one expected snapshot per clock, compared on the falling edge.
  snap_t mon_exp;
  snap_t mon_act;
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_empty cycle %0d: no expected entry queued", cyc);
        end else begin
          mon_exp = sb_q.pop_front();
          mon_act = '{bus.Grant, bus.GrantIndex, bus.GrantValid, bus.Timeout, bus.PendingVec};
          if (mon_act !== mon_exp || bus.AnyPending !== (|mon_exp.pend)) begin
            n_fail++;
            $display("FAIL outputs cycle %0d: got grant=%h idx=%0d vld=%b to=%b pend=%h any=%b, expected grant=%h idx=%0d vld=%b to=%b pend=%h any=%b",
                     cyc, mon_act.grant, mon_act.idx, mon_act.vld, mon_act.tout, mon_act.pend, bus.AnyPending,
                     mon_exp.grant, mon_exp.idx, mon_exp.vld, mon_exp.tout, mon_exp.pend, |mon_exp.pend);
          end
        end
      end
    end
  end

  task automatic check_zero(input string nm);
    n_tests++;
    if (bus.Grant !== 18'd0 || bus.GrantIndex !== 5'd0 || bus.GrantValid !== 1'b0 ||
        bus.Timeout !== 1'b0 || bus.PendingVec !== 18'd0 || bus.AnyPending !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got grant=%h idx=%0d vld=%b to=%b pend=%h any=%b, expected all zero",
               nm, bus.Grant, bus.GrantIndex, bus.GrantValid, bus.Timeout, bus.PendingVec, bus.AnyPending);
    end
  endtask

  // mode 0: fully random request word; mode 1: sparse bit toggles
  task automatic drive(input int mode, input int ack_pct);
    logic [17:0] rq;
    rq = bus.Request;
    if (mode == 0) begin
      rq = 18'($urandom);
    end else begin
      for (int i = 0; i < 18; i++)
        if ($urandom_range(7) == 0) rq[i] = ~rq[i];
    end
    bus.Request = rq;
    bus.Ack     = ($urandom_range(99) < ack_pct);
  endtask

  task automatic run_cycles(input int n, input int mode, input int ack_pct);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      cyc++;
      model_step(bus.Request, bus.Ack);
      sb_q.push_back(model_snap());
      mon_en = 1'b1;
      #1;
      drive(mode, ack_pct);
    end
  endtask

  task automatic reset_mid_grant(input string nm);
    int guard = 0;
    while (!(m_gidx >= 0 && model_pend_count() >= 3) && guard < 300) begin
      run_cycles(1, 1, 0);
      guard++;
    end
    if (guard >= 300) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_setup: got no grant with 3 pending within 300 cycles, expected one", nm);
    end
    mon_en = 1'b0;
    sb_q.delete();
    rst = 1'b1;
    #1;
    check_zero(nm);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    bus.Request = 18'd0;
    bus.Ack     = 1'b0;
    model_reset();
    #3;
    check_zero("reset_init");
    #4;
    rst = 1'b0;

    run_cycles(400, 1, 30);
    run_cycles(300, 0, 50);
    run_cycles(300, 1, 0);
    reset_mid_grant("reset_mid_grant_a");
    run_cycles(400, 1, 15);
    run_cycles(200, 0, 90);
    reset_mid_grant("reset_mid_grant_b");
    run_cycles(300, 1, 40);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
